// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the digit-serial ALU.
package alu_seq_pkg;

  localparam int unsigned DIGITS_DEFAULT = 4;
  localparam int unsigned DIGIT_W        = 3;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ADC   = 3'b001,
    OP_SUB   = 3'b010,
    OP_SBC   = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSA = 3'b101,
    OP_PASSB = 3'b110,
    OP_ZERO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice controls: ns gates A, n gates B, nx enables the carry chain.
  typedef struct packed {
    logic ns;
    logic n;
    logic nx;
  } slice_ctl_t;

  function automatic slice_ctl_t op_ctl(input op_e op);
    slice_ctl_t ctl;
    ctl = '{ns: 1'b0, n: 1'b0, nx: 1'b0};
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: ctl = '{ns: 1'b1, n: 1'b1, nx: 1'b1};
      OP_XOR:                         ctl = '{ns: 1'b1, n: 1'b1, nx: 1'b0};
      OP_PASSA:                       ctl = '{ns: 1'b1, n: 1'b0, nx: 1'b0};
      OP_PASSB:                       ctl = '{ns: 1'b0, n: 1'b1, nx: 1'b0};
      default:                        ctl = '{ns: 1'b0, n: 1'b0, nx: 1'b0};
    endcase
    return ctl;
  endfunction

  // Arithmetic ops occupy the lower half of the opcode space.
  function automatic logic op_is_arith(input op_e op);
    return ~op[2];
  endfunction

  function automatic logic op_inv_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_seq12_alu3.sv
// 3-bit ALU slice: gated A/B, XOR-sum with optional ripple carry.
module alu3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       nx,
  input  logic       c_in,
  input  logic       ns,
  input  logic       n,
  output logic [2:0] q,
  output logic [1:0] c,
  output logic       c_out
);

  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [3:0] w_cy;

  assign w_x = a & {3{ns}};
  assign w_y = b & {3{n}};

  // Ripple the carry across the three bits; carries stay zero when nx=0.
  always_comb begin
    w_cy    = '0;
    q       = '0;
    w_cy[0] = c_in & nx;
    for (int i = 0; i < 3; i++) begin
      q[i]      = w_x[i] ^ w_y[i] ^ w_cy[i];
      w_cy[i+1] = nx & ((w_x[i] & w_y[i]) | (w_x[i] & w_cy[i]) | (w_y[i] & w_cy[i]));
    end
  end

  assign c     = w_cy[2:1];
  assign c_out = w_cy[3];

endmodule

// File: rtl/alu_seq12.sv
// Digit-serial ALU: one 3-bit digit per cycle through a shared alu3 slice.
module alu_seq12
  import alu_seq_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [DIGIT_W*DIGITS-1:0]   a,
  input  logic [DIGIT_W*DIGITS-1:0]   b,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   q,
  output logic                        flag_c,
  output logic                        flag_z,
  output logic                        flag_n,
  output logic                        flag_v
);

  localparam int unsigned W  = DIGIT_W * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_last;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_res;
  op_e              r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_q;
  logic             r_flag_c;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_v;

  slice_ctl_t       w_ctl;
  logic [2:0]       w_sq;
  logic [1:0]       w_c;
  logic             w_cout;
  logic             w_unused_c0;
  logic             w_cin0;
  logic             w_arith;
  logic [W+2:0]     w_cat;
  logic [W-1:0]     w_res_full;
  op_e              w_op_in;

  assign w_op_in     = op_e'(op);
  assign w_ctl       = op_ctl(r_op);
  assign w_arith     = op_is_arith(r_op);
  assign w_unused_c0 = w_c[0];
  assign w_cat       = {w_sq, r_res};
  assign w_res_full  = w_cat[W+2:3];

  alu3 u_slice (
    .a     (r_a[2:0]),
    .b     (r_b[2:0]),
    .nx    (w_ctl.nx),
    .c_in  (r_carry),
    .ns    (w_ctl.ns),
    .n     (w_ctl.n),
    .q     (w_sq),
    .c     (w_c),
    .c_out (w_cout)
  );

  // Digit-0 carry-in chosen from the opcode being accepted.
  always_comb begin
    w_cin0 = 1'b0;
    case (w_op_in)
      OP_SUB:         w_cin0 = 1'b1;
      OP_ADC, OP_SBC: w_cin0 = r_flag_c;
      default:        w_cin0 = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_last = (r_cnt == CW'(DIGITS - 1));
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered status outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, digit shifting, and result/flag load on the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_q      <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_a     <= a;
        r_b     <= b ^ {W{op_inv_b(w_op_in)}};
        r_op    <= w_op_in;
        r_cnt   <= '0;
        r_carry <= w_cin0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> DIGIT_W;
        r_b     <= r_b >> DIGIT_W;
        r_res   <= w_res_full;
        r_carry <= w_cout;
        if (!w_last) r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_q      <= w_res_full;
          r_flag_c <= w_arith & w_cout;
          r_flag_v <= w_arith & (w_cout ^ w_c[1]);
          r_flag_z <= ~|w_res_full;
          r_flag_n <= w_res_full[W-1];
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign q      = r_q;
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
  assign flag_v = r_flag_v;

endmodule

// File: doc/alu_seq12.md
ALU_SEQ12 -- requirements
Module: alu_seq12

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 3-bit digits per operand; word width W = 3*DIGITS (12 at default).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3, opcode: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 XOR, 101 PASSA, 110 PASSB, 111 ZERO.
REQ-006 SHALL have port a, input, W, operand A.
REQ-007 SHALL have port b, input, W, operand B.
REQ-008 SHALL have port busy, output, 1, high while the operation is in progress (RUN).
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port q, output, W, registered result.
REQ-011 SHALL have ports flag_c, flag_z, flag_n, flag_v, output, 1 each: carry, zero, negative and signed-overflow flags, all registered.

Function
REQ-012 SHALL implement state machine IDLE -> RUN -> DONE -> IDLE.
REQ-013 SHALL, in IDLE with start=1, capture a, b and op, clear the digit counter, and enter RUN on the next edge; start=0 keeps IDLE.
REQ-014 SHALL process one 3-bit digit per RUN cycle, least-significant digit first, for exactly DIGITS cycles, then enter DONE.
REQ-015 SHALL, in DONE, assert done=1 for one cycle and return to IDLE unconditionally; busy=0 in DONE.
REQ-016 SHALL load q and all flags on the edge that enters DONE, and hold them until the next DONE entry; q SHALL NOT change during RUN.
REQ-017 SHALL fix latency: start at cycle T -> busy high T+1..T+DIGITS -> done high at T+DIGITS+1.
REQ-018 SHALL ignore start while in RUN or DONE; there is no queueing and a lost request is not reported.
REQ-019 SHALL drive slice controls per op:
- ADD, ADC, SUB, SBC: ns=1, n=1, nx=1.
- XOR: ns=1, n=1, nx=0.
- PASSA: ns=1, n=0, nx=0.
- PASSB: ns=0, n=1, nx=0.
- ZERO: ns=0, n=0, nx=0.
REQ-020 SHALL feed B inverted (one's complement) to the slice for SUB and SBC, and B unmodified otherwise.
REQ-021 SHALL set digit-0 carry-in: ADD=0, SUB=1, ADC and SBC = flag_c as held at start acceptance.
REQ-022 SHALL set digit k>0 carry-in to the registered c_out of digit k-1.
REQ-023 SHALL set flags for arithmetic ops:
- flag_c = c_out of the final digit; for SUB/SBC, 1 means no borrow.
- flag_v = final-digit c_out XOR final-digit c[1] (carry into bit W-1).
REQ-024 SHALL set flag_c=0 and flag_v=0 for XOR, PASSA, PASSB and ZERO.
REQ-025 SHALL set flag_z=1 iff all W result bits are zero, and flag_n = result bit W-1, for every op.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, enter IDLE and clear busy, done, q, all flags, the digit counter and the internal carry, regardless of state.
REQ-027 SHALL, on reset during RUN, discard the partial result with no done pulse; reset SHALL take priority over start.

Structure
REQ-028 SHALL place the opcode constants, the state encoding and the DIGITS default in a shared package, alu_seq_pkg.
REQ-029 SHALL instantiate exactly one existing alu3 slice as its sub-module (3-bit a/b, nx, c_in, ns, n -> q, c[1:0], c_out), reused for every digit.
REQ-030 SHALL use a digit counter of ceil(log2(DIGITS)) bits that is not advanced outside RUN.

Verification
REQ-031 SHALL cover: ADD a=0x7FF, b=0x001 -> q=0x800, C=0, Z=0, N=1, V=1, with done exactly 5 cycles after start.
REQ-032 SHALL cover: SUB a=0x005, b=0x005 -> q=0x000, C=1, Z=1, N=0, V=0.
REQ-033 SHALL cover carry chaining: ADD 0xFFF+0x001 -> q=0x000, C=1, Z=1; then ADC 0x000+0x000 -> q=0x001, C=0, Z=0.
REQ-034 SHALL cover: XOR 0xA5A, 0x0FF -> q=0xAA5, C=0, V=0, N=1; then PASSB with b=0x123 -> q=0x123.
REQ-035 SHALL cover: start held high throughout RUN -> only one operation executes, one done pulse, then IDLE.
REQ-036 SHALL cover: reset at T+2 of an ADD -> next cycle busy=0, done=0, q=0x000, all flags 0, and no later done pulse.
